// File: rtl/multicycle_sequencer_pkg.sv
// Shared definitions for the multi-cycle sequencer: state codes, opcode
// constants and PC source select codes.
package multicycle_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } state_e;

    localparam logic [3:0] OP_LW   = 4'd8;
    localparam logic [3:0] OP_SW   = 4'd9;
    localparam logic [3:0] OP_BEQ  = 4'd10;
    localparam logic [3:0] OP_BNE  = 4'd11;
    localparam logic [3:0] OP_JMP  = 4'd12;
    localparam logic [3:0] OP_NOP  = 4'd14;
    localparam logic [3:0] OP_HALT = 4'd15;

    localparam logic [1:0] PCSRC_INC = 2'd0;
    localparam logic [1:0] PCSRC_BR  = 2'd1;
    localparam logic [1:0] PCSRC_JMP = 2'd2;

endpackage

// File: rtl/multicycle_sequencer_op_class_decode.sv
// Combinational opcode classifier. Anything not explicitly named is an
// ALU operation (0-7 and 13).
module multicycle_sequencer_op_class_decode
    import multicycle_sequencer_pkg::*;
#(
    parameter int OPC_W = 4
) (
    input  logic [OPC_W-1:0] op_i,
    output logic             is_alu_o,
    output logic             is_lw_o,
    output logic             is_sw_o,
    output logic             is_br_o,
    output logic             is_bne_o,
    output logic             is_jmp_o,
    output logic             is_nop_o,
    output logic             is_halt_o
);

    assign is_lw_o   = (op_i == OPC_W'(OP_LW));
    assign is_sw_o   = (op_i == OPC_W'(OP_SW));
    assign is_bne_o  = (op_i == OPC_W'(OP_BNE));
    assign is_br_o   = (op_i == OPC_W'(OP_BEQ)) || is_bne_o;
    assign is_jmp_o  = (op_i == OPC_W'(OP_JMP));
    assign is_nop_o  = (op_i == OPC_W'(OP_NOP));
    assign is_halt_o = (op_i == OPC_W'(OP_HALT));
    assign is_alu_o  = ~(is_lw_o | is_sw_o | is_br_o | is_jmp_o | is_nop_o | is_halt_o);

endmodule

// File: rtl/multicycle_sequencer.sv
// Multi-cycle CPU control FSM: steps one instruction at a time through
// FETCH/DECODE/EXEC/MEM/WB, drives the timing strobes and counts retirements.
module multicycle_sequencer
    import multicycle_sequencer_pkg::*;
#(
    parameter int OPC_W = 4,
    parameter int RET_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [OPC_W-1:0] Opcode,
    input  logic             Zero,
    input  logic             Mem_ack,
    output logic             Mem_req,
    output logic             Mem_sel,
    output logic             IR_write,
    output logic             PC_write,
    output logic [1:0]       PC_src,
    output logic             Reg_write,
    output logic             Data_write,
    output logic             Halted,
    output logic [2:0]       State,
    output logic [RET_W-1:0] Retired
);

    state_e             state_q, state_d;
    logic [OPC_W-1:0]   op_q, op_d;
    logic [RET_W-1:0]   ret_q, ret_d;
    logic               run_q;
    logic               retire;
    logic               is_alu, is_lw, is_sw, is_br, is_bne, is_jmp, is_nop, is_halt;

    // DECODE classifies the live opcode; later states use the latched copy.
    assign op_d  = (state_q == ST_DECODE) ? Opcode : op_q;
    assign ret_d = retire ? ret_q + RET_W'(1) : ret_q;

    multicycle_sequencer_op_class_decode #(
        .OPC_W (OPC_W)
    ) u_op_class (
        .op_i      (op_d),
        .is_alu_o  (is_alu),
        .is_lw_o   (is_lw),
        .is_sw_o   (is_sw),
        .is_br_o   (is_br),
        .is_bne_o  (is_bne),
        .is_jmp_o  (is_jmp),
        .is_nop_o  (is_nop),
        .is_halt_o (is_halt)
    );

    // run_q keeps FETCH quiet while reset is held and for the release cycle,
    // so Mem_req rises only on the first cycle after reset is sampled high.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_FETCH;
            op_q    <= '0;
            ret_q   <= '0;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            ret_q   <= ret_d;
            run_q   <= 1'b1;
        end
    end

    always_comb begin
        state_d    = state_q;
        Mem_req    = 1'b0;
        Mem_sel    = 1'b0;
        IR_write   = 1'b0;
        PC_write   = 1'b0;
        PC_src     = PCSRC_INC;
        Reg_write  = 1'b0;
        Data_write = 1'b0;
        Halted     = 1'b0;
        retire     = 1'b0;
        case (state_q)
            ST_FETCH: begin
                if (run_q) begin
                    Mem_req = 1'b1;
                    if (Mem_ack) begin
                        IR_write = 1'b1;
                        PC_write = 1'b1;
                        state_d  = ST_DECODE;
                    end
                end
            end
            ST_DECODE: begin
                if (is_jmp) begin
                    PC_write = 1'b1;
                    PC_src   = PCSRC_JMP;
                    retire   = 1'b1;
                    state_d  = ST_FETCH;
                end else if (is_nop) begin
                    retire  = 1'b1;
                    state_d = ST_FETCH;
                end else if (is_halt) begin
                    retire  = 1'b1;
                    state_d = ST_HALT;
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (is_br) begin
                    PC_src   = PCSRC_BR;
                    PC_write = Zero ^ is_bne;
                    retire   = 1'b1;
                    state_d  = ST_FETCH;
                end else if (is_lw || is_sw) begin
                    state_d = ST_MEM;
                end else if (is_alu) begin
                    state_d = ST_WB;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_MEM: begin
                Mem_req    = 1'b1;
                Mem_sel    = 1'b1;
                Data_write = is_sw;
                if (Mem_ack) begin
                    retire  = is_sw;
                    state_d = is_sw ? ST_FETCH : ST_WB;
                end
            end
            ST_WB: begin
                Reg_write = 1'b1;
                retire    = 1'b1;
                state_d   = ST_FETCH;
            end
            ST_HALT: begin
                Halted = 1'b1;
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase
    end

    assign State   = state_q;
    assign Retired = ret_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed bench for multicycle_sequencer: a per-cycle vector table for the
// instruction flows plus hand sequences for reset abort and counter wrap.
module tb_multicycle_sequencer;

    // A narrow retire counter keeps the wrap-around run short.
    localparam int RW = 8;

    logic          clk;
    logic          rst_n;
    logic [3:0]    Opcode;
    logic          Zero;
    logic          Mem_ack;
    logic          Mem_req;
    logic          Mem_sel;
    logic          IR_write;
    logic          PC_write;
    logic [1:0]    PC_src;
    logic          Reg_write;
    logic          Data_write;
    logic          Halted;
    logic [2:0]    State;
    logic [RW-1:0] Retired;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic        rst_n;
        logic [3:0]  op;
        logic        zero;
        logic        ack;
        logic [19:0] exp;
    } vec_t;

    vec_t vecs[$];

    multicycle_sequencer #(
        .OPC_W (4),
        .RET_W (RW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .Opcode     (Opcode),
        .Zero       (Zero),
        .Mem_ack    (Mem_ack),
        .Mem_req    (Mem_req),
        .Mem_sel    (Mem_sel),
        .IR_write   (IR_write),
        .PC_write   (PC_write),
        .PC_src     (PC_src),
        .Reg_write  (Reg_write),
        .Data_write (Data_write),
        .Halted     (Halted),
        .State      (State),
        .Retired    (Retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected word layout: {state, req, sel, irw, pcw, pcsrc[1:0], rw, dw, halted, retired[7:0]}
    task automatic add(input int r, input int op, input int z, input int a,
                       input int st, input int req, input int sel, input int irw,
                       input int pcw, input int pcs, input int rw, input int dw,
                       input int hlt, input int ret);
        vec_t v;
        v.rst_n = 1'(r);
        v.op    = 4'(op);
        v.zero  = 1'(z);
        v.ack   = 1'(a);
        v.exp   = {3'(st), 1'(req), 1'(sel), 1'(irw), 1'(pcw), 2'(pcs),
                   1'(rw), 1'(dw), 1'(hlt), 8'(ret)};
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, req);
        end else begin
            $display("ok   %s: %0d", name, act);
        end
    endtask

    initial begin
        logic [19:0] got;

        //   rst op  z  a | st req sel irw pcw pcs rw dw hlt ret
        // ALU (opcode 0), zero-wait memory: FETCH, DECODE, EXEC, WB
        add(0,  0, 0, 1,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(1,  0, 0, 1,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(1,  0, 0, 1,  0, 1, 0, 1, 1, 0, 0, 0, 0, 0);
        add(1,  0, 0, 1,  1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(1,  0, 0, 1,  2, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(1,  0, 0, 1,  4, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        // LW: one stalled fetch cycle, opcode changed after DECODE, 3-cycle MEM
        add(1,  8, 0, 0,  0, 1, 0, 0, 0, 0, 0, 0, 0, 1);
        add(1,  8, 0, 1,  0, 1, 0, 1, 1, 0, 0, 0, 0, 1);
        add(1,  8, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        add(1,  0, 0, 0,  2, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        add(1,  0, 0, 0,  3, 1, 1, 0, 0, 0, 0, 0, 0, 1);
        add(1,  0, 0, 0,  3, 1, 1, 0, 0, 0, 0, 0, 0, 1);
        add(1,  0, 0, 1,  3, 1, 1, 0, 0, 0, 0, 0, 0, 1);
        add(1,  0, 0, 0,  4, 0, 0, 0, 0, 0, 1, 0, 0, 1);
        // BEQ taken (Z=1), BNE not taken (Z=1), BNE taken (Z=0)
        add(1, 10, 1, 1,  0, 1, 0, 1, 1, 0, 0, 0, 0, 2);
        add(1, 10, 1, 0,  1, 0, 0, 0, 0, 0, 0, 0, 0, 2);
        add(1, 10, 1, 0,  2, 0, 0, 0, 1, 1, 0, 0, 0, 2);
        add(1, 11, 1, 1,  0, 1, 0, 1, 1, 0, 0, 0, 0, 3);
        add(1, 11, 1, 0,  1, 0, 0, 0, 0, 0, 0, 0, 0, 3);
        add(1, 11, 1, 0,  2, 0, 0, 0, 0, 1, 0, 0, 0, 3);
        add(1, 11, 0, 1,  0, 1, 0, 1, 1, 0, 0, 0, 0, 4);
        add(1, 11, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0, 0, 4);
        add(1, 11, 0, 0,  2, 0, 0, 0, 1, 1, 0, 0, 0, 4);
        // SW: Data_write steady through a stalled MEM, then straight to FETCH
        add(1,  9, 0, 1,  0, 1, 0, 1, 1, 0, 0, 0, 0, 5);
        add(1,  9, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0, 0, 5);
        add(1,  9, 0, 0,  2, 0, 0, 0, 0, 0, 0, 0, 0, 5);
        add(1,  9, 0, 0,  3, 1, 1, 0, 0, 0, 0, 1, 0, 5);
        add(1,  9, 0, 1,  3, 1, 1, 0, 0, 0, 0, 1, 0, 5);
        // JMP and NOP retire in DECODE
        add(1, 12, 0, 1,  0, 1, 0, 1, 1, 0, 0, 0, 0, 6);
        add(1, 12, 0, 0,  1, 0, 0, 0, 1, 2, 0, 0, 0, 6);
        add(1, 14, 0, 1,  0, 1, 0, 1, 1, 0, 0, 0, 0, 7);
        add(1, 14, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0, 0, 7);
        // HALT: terminal, retires once, no Mem_req; reset clears the count
        add(1, 15, 0, 1,  0, 1, 0, 1, 1, 0, 0, 0, 0, 8);
        add(1, 15, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0, 0, 8);
        add(1, 15, 0, 1,  5, 0, 0, 0, 0, 0, 0, 0, 1, 9);
        add(1,  0, 0, 1,  5, 0, 0, 0, 0, 0, 0, 0, 1, 9);
        add(0,  0, 0, 1,  5, 0, 0, 0, 0, 0, 0, 0, 1, 9);
        add(1,  0, 0, 1,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(1,  0, 0, 0,  0, 1, 0, 0, 0, 0, 0, 0, 0, 0);

        rst_n   = 1'b0;
        Opcode  = 4'd0;
        Zero    = 1'b0;
        Mem_ack = 1'b0;
        repeat (2) @(posedge clk);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            rst_n   = vecs[i].rst_n;
            Opcode  = vecs[i].op;
            Zero    = vecs[i].zero;
            Mem_ack = vecs[i].ack;
            #1;
            got = {State, Mem_req, Mem_sel, IR_write, PC_write, PC_src,
                   Reg_write, Data_write, Halted, Retired};
            n_cmp++;
            if (got !== vecs[i].exp) begin
                n_bad++;
                $display("FAIL vec%0d: actual=%05h required=%05h", i, got, vecs[i].exp);
            end else begin
                $display("ok   vec%0d: %05h", i, got);
            end
        end

        // Reset during a stalled fetch, with an ack arriving while reset is held
        @(negedge clk);
        rst_n   = 1'b0;
        Mem_ack = 1'b0;
        #1 chk("stall_req_before_reset", int'(Mem_req), 1);
        @(negedge clk);
        Mem_ack = 1'b1;
        #1;
        chk("rst_ack_ir_write", int'(IR_write), 0);
        chk("rst_ack_mem_req", int'(Mem_req), 0);
        chk("rst_ack_pc_write", int'(PC_write), 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("release_ir_write", int'(IR_write), 0);
        chk("release_retired", int'(Retired), 0);

        // Back-to-back NOPs, 2 cycles each, until the counter wraps
        @(negedge clk);
        Opcode  = 4'd14;
        Mem_ack = 1'b1;
        #1;
        chk("nop_first_fetch_irw", int'(IR_write), 1);
        chk("nop_first_fetch_state", int'(State), 0);
        repeat (2 * 128) @(posedge clk);
        @(negedge clk);
        #1 chk("retired_after_128_nops", int'(Retired), 128);
        repeat (2 * 127) @(posedge clk);
        @(negedge clk);
        #1 chk("retired_after_255_nops", int'(Retired), 255);
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk("retired_wraps_to_zero", int'(Retired), 0);
        chk("state_after_wrap", int'(State), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
